// File: rtl/pipeline_pkg.sv
// Shared widths, the EX/MEM record layout and its bubble constant for the scalar/vector core.
package pipeline_pkg;

  localparam int SDATA_W = 32;
  localparam int VDATA_W = 128;
  localparam int REG_AW  = 5;

  typedef struct packed {
    logic               valid;
    logic [REG_AW-1:0]  rd;
    logic               write_enable;
    logic               wb_sel;
    logic               mem_write;
    logic               vector;
    logic [SDATA_W-1:0] addr;
    logic [VDATA_W-1:0] result;
    logic [VDATA_W-1:0] store_data;
  } ex_mem_t;

  localparam ex_mem_t EX_MEM_BUBBLE = '0;

  // Scalar results travel zero-extended so forwarding always sees a full vector-width word.
  function automatic logic [VDATA_W-1:0] select_result(
    input logic               is_vector,
    input logic [SDATA_W-1:0] scalar_result,
    input logic [VDATA_W-1:0] vector_result
  );
    if (is_vector) begin
      return vector_result;
    end else begin
      return {{(VDATA_W-SDATA_W){1'b0}}, scalar_result};
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Count qualifying edges, holding once the counter is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (inc && (count_r != {WIDTH{1'b1}})) begin
      count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/ex_mem_pipeline_reg.sv
// EX/MEM pipeline register: captures EX results, inserts bubbles on stall/flush, holds on mem_busy.
// Optional hazard statistics counters are enabled with the HAZARD_STATS_EN macro.
module ex_mem_pipeline_reg
  import pipeline_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_busy,
  input  logic               stall,
  input  logic               flush,
  input  logic               valid_ex,
  input  logic               vector_ex,
  input  logic [REG_AW-1:0]  rd_ex,
  input  logic               write_enable_ex,
  input  logic               wb_sel_ex,
  input  logic               mem_write_ex,
  input  logic [SDATA_W-1:0] alu_result_ex,
  input  logic [VDATA_W-1:0] valu_result_ex,
  input  logic [VDATA_W-1:0] store_data_ex,
  output logic               valid_mem,
  output logic [REG_AW-1:0]  rd_mem,
  output logic               write_enable_mem,
  output logic               wb_sel,
  output logic               mem_write_mem,
  output logic               vector_mem,
  output logic [SDATA_W-1:0] addr_mem,
  output logic [VDATA_W-1:0] result_mem,
  output logic [VDATA_W-1:0] store_data_mem,
  output logic               hazard_err
`ifdef HAZARD_STATS_EN
 ,output logic [15:0]        stall_count,
  output logic [15:0]        flush_count
`endif
);

  ex_mem_t mem_r;
  ex_mem_t mem_next_s;
  logic    hazard_err_r;
  logic    hazard_next_s;

  // Next MEM content: busy holds, flush/stall bubbles, otherwise capture with valid qualification.
  always_comb begin
    mem_next_s = mem_r;
    if (mem_busy) begin
      mem_next_s = mem_r;
    end else if (flush || stall) begin
      mem_next_s = EX_MEM_BUBBLE;
    end else begin
      mem_next_s.valid        = valid_ex;
      mem_next_s.rd           = rd_ex;
      mem_next_s.write_enable = write_enable_ex & valid_ex;
      mem_next_s.wb_sel       = wb_sel_ex;
      mem_next_s.mem_write    = mem_write_ex & valid_ex;
      mem_next_s.vector       = vector_ex;
      mem_next_s.addr         = alu_result_ex;
      mem_next_s.result       = select_result(vector_ex, alu_result_ex, valu_result_ex);
      mem_next_s.store_data   = store_data_ex;
    end
  end

  // A stall is only legitimate when a load (write-enabled, memory writeback) sits in MEM.
  always_comb begin
    hazard_next_s = hazard_err_r;
    if (stall && !mem_busy && (!mem_r.write_enable || mem_r.wb_sel)) begin
      hazard_next_s = 1'b1;
    end else begin
      hazard_next_s = hazard_err_r;
    end
  end

  // Pipeline state and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r        <= EX_MEM_BUBBLE;
      hazard_err_r <= 1'b0;
    end else begin
      mem_r        <= mem_next_s;
      hazard_err_r <= hazard_next_s;
    end
  end

  assign valid_mem        = mem_r.valid;
  assign rd_mem           = mem_r.rd;
  assign write_enable_mem = mem_r.write_enable;
  assign wb_sel           = mem_r.wb_sel;
  assign mem_write_mem    = mem_r.mem_write;
  assign vector_mem       = mem_r.vector;
  assign addr_mem         = mem_r.addr;
  assign result_mem       = mem_r.result;
  assign store_data_mem   = mem_r.store_data;
  assign hazard_err       = hazard_err_r;

`ifdef HAZARD_STATS_EN
  // Flush wins attribution when both bubble causes are present.
  logic flush_inc_s;
  logic stall_inc_s;

  assign flush_inc_s = ~mem_busy & flush;
  assign stall_inc_s = ~mem_busy & stall & ~flush;

  sat_counter #(.WIDTH(16)) u_stall_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc_s),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(16)) u_flush_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc_s),
    .count (flush_count)
  );
`endif

endmodule

// File: tb/tb_ex_mem_pipeline_reg.sv
// Directed self-checking bench for ex_mem_pipeline_reg (counter checks under HAZARD_STATS_EN).
module tb_ex_mem_pipeline_reg;

  logic         clk;
  logic         rst_n;
  logic         mem_busy;
  logic         stall;
  logic         flush;
  logic         valid_ex;
  logic         vector_ex;
  logic [4:0]   rd_ex;
  logic         write_enable_ex;
  logic         wb_sel_ex;
  logic         mem_write_ex;
  logic [31:0]  alu_result_ex;
  logic [127:0] valu_result_ex;
  logic [127:0] store_data_ex;
  logic         valid_mem;
  logic [4:0]   rd_mem;
  logic         write_enable_mem;
  logic         wb_sel;
  logic         mem_write_mem;
  logic         vector_mem;
  logic [31:0]  addr_mem;
  logic [127:0] result_mem;
  logic [127:0] store_data_mem;
  logic         hazard_err;
`ifdef HAZARD_STATS_EN
  logic [15:0]  stall_count;
  logic [15:0]  flush_count;
`endif

  int checks;
  int failures;

  localparam logic [127:0] V5A = 128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A;
  localparam logic [127:0] VC3 = 128'hC3C3C3C3_11223344_55667788_99AABBCC;

  ex_mem_pipeline_reg dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_busy         (mem_busy),
    .stall            (stall),
    .flush            (flush),
    .valid_ex         (valid_ex),
    .vector_ex        (vector_ex),
    .rd_ex            (rd_ex),
    .write_enable_ex  (write_enable_ex),
    .wb_sel_ex        (wb_sel_ex),
    .mem_write_ex     (mem_write_ex),
    .alu_result_ex    (alu_result_ex),
    .valu_result_ex   (valu_result_ex),
    .store_data_ex    (store_data_ex),
    .valid_mem        (valid_mem),
    .rd_mem           (rd_mem),
    .write_enable_mem (write_enable_mem),
    .wb_sel           (wb_sel),
    .mem_write_mem    (mem_write_mem),
    .vector_mem       (vector_mem),
    .addr_mem         (addr_mem),
    .result_mem       (result_mem),
    .store_data_mem   (store_data_mem),
    .hazard_err       (hazard_err)
`ifdef HAZARD_STATS_EN
   ,.stall_count      (stall_count),
    .flush_count      (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_ex(input logic v, input logic vec, input logic [4:0] rd, input logic we,
                          input logic wb, input logic mw, input logic [31:0] alu,
                          input logic [127:0] valu, input logic [127:0] sd);
    valid_ex = v; vector_ex = vec; rd_ex = rd; write_enable_ex = we;
    wb_sel_ex = wb; mem_write_ex = mw; alu_result_ex = alu;
    valu_result_ex = valu; store_data_ex = sd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0; mem_busy = 1'b0; stall = 1'b0; flush = 1'b0;
    drive_ex(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 128'h0, 128'h0);
    #12;
    check("rst_valid", {127'h0, valid_mem}, 128'h0);
    check("rst_result", result_mem, 128'h0);
    check("rst_hazard", {127'h0, hazard_err}, 128'h0);
    rst_n = 1'b1;
    tick();

    // Scalar ADD capture
    drive_ex(1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, VC3, 128'h0);
    tick();
    check("add_rd", {123'h0, rd_mem}, 128'd3);
    check("add_result", result_mem, {96'h0, 32'hDEADBEEF});
    check("add_we", {127'h0, write_enable_mem}, 128'd1);
    check("add_wbsel", {127'h0, wb_sel}, 128'd1);
    check("add_addr", {96'h0, addr_mem}, {96'h0, 32'hDEADBEEF});

    // Store with valid_ex=0 must be qualified off
    drive_ex(1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1, 32'h40, 128'h0, VC3);
    tick();
    check("inv_valid", {127'h0, valid_mem}, 128'h0);
    check("inv_mw", {127'h0, mem_write_mem}, 128'h0);
    check("inv_we", {127'h0, write_enable_mem}, 128'h0);
    drive_ex(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h80, 128'h0, VC3);
    tick();
    check("st_mw", {127'h0, mem_write_mem}, 128'd1);
    check("st_data", store_data_mem, VC3);
    check("st_rd0", {123'h0, rd_mem}, 128'd0);

    // Load-use: load in MEM, stall bubbles, then held EX instruction captured
    drive_ex(1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 32'h100, 128'h0, 128'h0);
    tick();
    check("ld_rd", {123'h0, rd_mem}, 128'd7);
    drive_ex(1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 32'h1234, 128'h0, 128'h0);
    stall = 1'b1;
    tick();
    check("lu_valid", {127'h0, valid_mem}, 128'h0);
    check("lu_we", {127'h0, write_enable_mem}, 128'h0);
    check("lu_rd", {123'h0, rd_mem}, 128'h0);
    check("lu_hazard", {127'h0, hazard_err}, 128'h0);
    stall = 1'b0;
    tick();
    check("lu_resume_rd", {123'h0, rd_mem}, 128'd8);
    check("lu_resume_res", result_mem, {96'h0, 32'h1234});
`ifdef HAZARD_STATS_EN
    check("lu_stall_cnt", {112'h0, stall_count}, 128'd1);
`endif

    // Flush and stall together with a load in MEM
    drive_ex(1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 32'h200, 128'h0, 128'h0);
    tick();
    flush = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    check("fs_valid", {127'h0, valid_mem}, 128'h0);
    check("fs_hazard", {127'h0, hazard_err}, 128'h0);
`ifdef HAZARD_STATS_EN
    check("fs_flush_cnt", {112'h0, flush_count}, 128'd1);
    check("fs_stall_cnt", {112'h0, stall_count}, 128'd1);
`endif

    // Vector capture, then mem_busy with stall for 3 cycles
    drive_ex(1'b1, 1'b1, 5'd10, 1'b1, 1'b1, 1'b0, 32'h300, VC3, 128'h0);
    tick();
    check("vec_result", result_mem, VC3);
    check("vec_flag", {127'h0, vector_mem}, 128'd1);
    mem_busy = 1'b1; stall = 1'b1;
    drive_ex(1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1, 32'h999, V5A, V5A);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("busy_result", result_mem, VC3);
      check("busy_rd", {123'h0, rd_mem}, 128'd10);
      check("busy_hazard", {127'h0, hazard_err}, 128'h0);
    end
`ifdef HAZARD_STATS_EN
    check("busy_stall_cnt", {112'h0, stall_count}, 128'd1);
    check("busy_flush_cnt", {112'h0, flush_count}, 128'd1);
`endif

    // Stall with ALU result in MEM sets sticky hazard_err
    mem_busy = 1'b0;
    tick();
    check("herr_set", {127'h0, hazard_err}, 128'd1);
    check("herr_bubble", {127'h0, valid_mem}, 128'h0);
    stall = 1'b0;
    drive_ex(1'b1, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 32'h0, V5A, 128'h0);
    tick();
    tick();
    check("herr_sticky", {127'h0, hazard_err}, 128'd1);
    check("pre_rst_result", result_mem, V5A);

    // Asynchronous reset mid-run clears outputs before any edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_result", result_mem, 128'h0);
    check("arst_valid", {127'h0, valid_mem}, 128'h0);
    check("arst_hazard", {127'h0, hazard_err}, 128'h0);
`ifdef HAZARD_STATS_EN
    check("arst_stall_cnt", {112'h0, stall_count}, 128'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

`ifdef HAZARD_STATS_EN
    // Flush counter saturation
    drive_ex(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 128'h0, 128'h0);
    flush = 1'b1;
    repeat (65538) @(posedge clk);
    #1;
    flush = 1'b0;
    check("sat_flush_cnt", {112'h0, flush_count}, {112'h0, 16'hFFFF});
    check("sat_stall_cnt", {112'h0, stall_count}, 128'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
